// File: rtl/l0_maxpool_if.sv
// Interface between the layer-0 producer / downstream consumer and the
// l0_maxpool stage. The master side drives window data, the end-of-image
// pulse and the read address; the slave side is the pooling block.
interface l0_maxpool_if #(
  parameter int DW = 18,
  parameter int AW = 8
);
  logic          tx_done;
  logic          rdy_in;
  logic [DW-1:0] din_0;
  logic [DW-1:0] din_1;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] dout_0;
  logic [DW-1:0] dout_1;
  logic          rdy_out;
  logic [AW-1:0] wr_cnt;
  logic          done;

  modport master (
    output tx_done, rdy_in, din_0, din_1, addr_rd,
    input  dout_0, dout_1, rdy_out, wr_cnt, done
  );

  modport slave (
    input  tx_done, rdy_in, din_0, din_1, addr_rd,
    output dout_0, dout_1, rdy_out, wr_cnt, done
  );
endinterface

// File: rtl/l0_maxpool.sv
// 2x2 stride-2 max-pool stage behind the layer-0 conv/ReLU block.
// Follows the producer's fixed 5-cycle window cadence (IDLE + four reads),
// keeps a running unsigned maximum per channel and stores one pooled value
// per window into two pool RAMs, read back through a registered port.
module l0_maxpool #(
  parameter int DW    = 18,
  parameter int N_WIN = 169,
  parameter int AW    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  l0_maxpool_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3
  } state_t;

  localparam logic [AW-1:0] LAST_WIN = AW'(N_WIN - 1);

  state_t        state;
  logic [DW-1:0] max_0;
  logic [DW-1:0] max_1;
  logic [DW-1:0] wv_0;
  logic [DW-1:0] wv_1;
  logic [AW-1:0] win_cnt;
  logic          all_done;
  logic          wr_en;
  logic [DW-1:0] rd_0;
  logic [DW-1:0] rd_1;

  logic [DW-1:0] ram_0 [N_WIN];
  logic [DW-1:0] ram_1 [N_WIN];

  // Running maximum including the current read; ties keep the held value.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with every output assigned,
    // sequential blocks use '<=' only; mixing them causes races and latches.
    wv_0 = (bus.din_0 > max_0) ? bus.din_0 : max_0;
    wv_1 = (bus.din_1 > max_1) ? bus.din_1 : max_1;
  end

  // A window is committed on its final read unless the image is being cleared.
  assign wr_en = (state == P3) && !bus.tx_done;

  // Window sequencer: tracks the producer cadence, holds maxima, counts windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      all_done <= 1'b0;
      max_0    <= '0;
      max_1    <= '0;
    end else if (bus.tx_done) begin
      // End of image wins over everything; a partial window is dropped.
      state    <= IDLE;
      win_cnt  <= '0;
      all_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.rdy_in && !all_done) state <= P0;
        end
        P0: begin
          max_0 <= bus.din_0;
          max_1 <= bus.din_1;
          state <= P1;
        end
        P1: begin
          max_0 <= wv_0;
          max_1 <= wv_1;
          state <= P2;
        end
        P2: begin
          max_0 <= wv_0;
          max_1 <= wv_1;
          state <= P3;
        end
        P3: begin
          win_cnt <= win_cnt + AW'(1);
          if (win_cnt == LAST_WIN) all_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pool RAM write port.
  // NOTE: the RAM arrays have no reset so they infer as block RAM; only
  // entries below wr_cnt are meaningful to the consumer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_0[win_cnt] <= wv_0;
      ram_1[win_cnt] <= wv_1;
    end
  end

  // Array read, kept apart from the reset register so the RAM read stays plain.
  always_comb begin
    rd_0 = ram_0[bus.addr_rd];
    rd_1 = ram_1[bus.addr_rd];
  end

  // Registered read port; a same-address write this cycle returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout_0 <= '0;
      bus.dout_1 <= '0;
    end else begin
      bus.dout_0 <= rd_0;
      bus.dout_1 <= rd_1;
    end
  end

  assign bus.rdy_out = (bus.addr_rd < win_cnt);
  assign bus.wr_cnt  = win_cnt;
  assign bus.done    = all_done;

endmodule
